control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle control unit for the 16-bit register-file/ULA datapath (r0–r7, rA, rR, operand multiplexer, ULA, output bus).
- Accepts one instruction word through a valid/ready handshake, latches it, and steps the datapath through load-A, load-R and write-back phases.
- Drives every enable and select line the datapath needs, replacing the free-running counter plus level-sensitive decode with a clocked Moore FSM.

Parameters:
- IW, 16, instruction word width.
- NREG, 8, number of general registers; sets the reg_we width.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset.
- instr_in  in  16  instruction word: [15:13] opcode, [12:10] Rx, [9:7] Ry, [9:0] immediate.
- instr_valid  in  1  instr_in is valid.
- instr_ready  out  1  sequencer can accept an instruction.
- reg_we  out  8  one-hot write enable for r0–r7.
- ra_we  out  1  rA load enable.
- rr_we  out  1  rR load enable.
- mux_sel  out  3  operand multiplexer register select.
- imm_sel  out  1  multiplexer selects the immediate.
- r_sel  out  1  multiplexer selects rR.
- imm_out  out  10  latched immediate (IR[9:0]).
- alu_op  out  3  ULA operation (IR[15:13]).
- bus_we  out  1  load the output bus register.
- busy  out  1  an instruction is in flight.
- done  out  1  one-cycle pulse in an instruction's final cycle.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
  - The ports are named clock and clear, as in the codebase counter.
- Opcodes:
  - ADD=000, SUB=001, AND=010, OR=011: Rx <- Rx op Ry.
  - OUT=100: bus <- Rx.
  - LDI=101: Rx <- imm, zero-extended to 16 bits.
  - MOV=110: Rx <- Ry.
  - NOP=111.
- FSM states: IDLE, LOAD_A, LOAD_R, WRITE.
  - Outputs are decoded combinationally from the state and the instruction register IR (Moore).
- IDLE: instr_ready=1, busy=0.
  - On instr_valid & instr_ready at a clock edge: IR <- instr_in.
  - Next state is WRITE for NOP, otherwise LOAD_A.
- LOAD_A: mux_sel=Rx, ra_we=1.
- LOAD_R: alu_op=IR[15:13], rr_we=1.
  - LDI: imm_sel=1.
  - ALU ops and MOV: mux_sel=Ry.
  - OUT: mux_sel=Rx.
- WRITE: done=1.
  - ALU, MOV, LDI: r_sel=1, reg_we[Rx]=1.
  - OUT: mux_sel=Rx, bus_we=1, reg_we=0.
  - NOP: all enables 0.
  - Next state is always IDLE.
- Latency:
  - Accept at edge n: LOAD_A in cycle n+1, LOAD_R in n+2, WRITE in n+3.
  - The destination register updates at the end of cycle n+3.
  - Throughput is one instruction per 4 cycles; NOP takes 2 cycles.
- instr_ready is 0 in every state except IDLE.
  - instr_in is ignored outside IDLE.
  - instr_valid held high gives an acceptance every 4th cycle.
- Defaults: every enable and select not listed for a state is 0.
  - imm_out always reflects IR[9:0].
  - reg_we is at most one-hot, never multi-hot.
- clear:
  - Next edge: state=IDLE, IR=0.
  - While clear=1, every enable output (reg_we, ra_we, rr_we, bus_we, done) is forced to 0 combinationally, so a mid-instruction reset never commits a write.
  - The interrupted instruction is dropped and is not replayed.
- clear and instr_valid in the same cycle: clear wins and nothing is accepted.
- Datapath registers have no reset; the sequencer owns only its state and IR.

Decomposition:
- Shared package (proc_pkg): opcode constants (ADD … NOP), state encoding, field bit positions.
  - The ULA uses the same opcode constants.
- One sub-module, instr_decoder: combinational, takes the state and IR and produces every output.
  - The FSM and IR stay in control_sequencer.

Test Plan:
- LDI R3,#0x155 (0xAD55): accept, then:
  - cycle+1: ra_we=1, mux_sel=3.
  - cycle+2: rr_we=1, imm_sel=1, alu_op=101, imm_out=0x155.
  - cycle+3: r_sel=1, reg_we=0x08, done=1.
  - Then instr_ready=1.
- ADD R1,R2 (0x0500):
  - cycle+1: mux_sel=1, ra_we=1.
  - cycle+2: mux_sel=2, rr_we=1, alu_op=000.
  - cycle+3: reg_we=0x02, r_sel=1.
- OUT R5 (0x9400): cycle+3 mux_sel=5, bus_we=1, reg_we=0, done=1.
- NOP (0xE000): done=1 in cycle+1, no enables asserted, instr_ready=1 in cycle+2.
- clear asserted during LOAD_R of ADD R1,R2:
  - No reg_we is ever asserted.
  - IDLE on the next cycle with all outputs 0.
  - IR reads 0.
- instr_valid held high with a stream 0xAD55, 0x0500, 0x9400:
  - instr_ready pattern is 1,0,0,0 repeating.
  - Three done pulses occur 4 cycles apart.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the register-file/ULA datapath: opcodes, sequencer
// states and instruction field positions.
package proc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_OUT = 3'b100,
    OP_LDI = 3'b101,
    OP_MOV = 3'b110,
    OP_NOP = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_R,
    ST_WRITE
  } state_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RX_MSB  = 12;
  localparam int RX_LSB  = 10;
  localparam int RY_MSB  = 9;
  localparam int RY_LSB  = 7;
  localparam int IMM_MSB = 9;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  function automatic logic is_alu_op(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Moore output decode: maps the sequencer state and latched instruction to
// every datapath enable and select line.
module instr_decoder
  import proc_pkg::*;
#(
  parameter int IW   = 16,
  parameter int NREG = 8
) (
  input  state_t            state,
  input  logic [IW-1:0]     ir,
  output logic              instr_ready,
  output logic [NREG-1:0]   reg_we,
  output logic              ra_we,
  output logic              rr_we,
  output logic [2:0]        mux_sel,
  output logic              imm_sel,
  output logic              r_sel,
  output logic [IMM_W-1:0]  imm_out,
  output logic [2:0]        alu_op,
  output logic              bus_we,
  output logic              busy,
  output logic              done
);

  opcode_t    op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       writes_reg;

  assign op         = opcode_t'(ir[OP_MSB:OP_LSB]);
  assign rx         = ir[RX_MSB:RX_LSB];
  assign ry         = ir[RY_MSB:RY_LSB];
  assign writes_reg = is_alu_op(op) || (op == OP_MOV) || (op == OP_LDI);
  assign imm_out    = ir[IMM_MSB:IMM_LSB];

  always_comb begin
    instr_ready = 1'b0;
    reg_we      = '0;
    ra_we       = 1'b0;
    rr_we       = 1'b0;
    mux_sel     = 3'd0;
    imm_sel     = 1'b0;
    r_sel       = 1'b0;
    alu_op      = 3'd0;
    bus_we      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_LOAD_A: begin
        mux_sel = rx;
        ra_we   = 1'b1;
      end
      ST_LOAD_R: begin
        alu_op = ir[OP_MSB:OP_LSB];
        rr_we  = 1'b1;
        if (op == OP_LDI)
          imm_sel = 1'b1;
        else if (op == OP_OUT)
          mux_sel = rx;
        else if (is_alu_op(op) || (op == OP_MOV))
          mux_sel = ry;
      end
      ST_WRITE: begin
        done = 1'b1;
        if (writes_reg) begin
          r_sel  = 1'b1;
          reg_we = NREG'(1) << rx;
        end else if (op == OP_OUT) begin
          mux_sel = rx;
          bus_we  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle Moore sequencer for the register-file/ULA datapath: accepts one
// instruction via valid/ready and steps it through LOAD_A, LOAD_R and WRITE.
module control_sequencer
  import proc_pkg::*;
#(
  parameter int IW   = 16,
  parameter int NREG = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [IW-1:0]     instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [NREG-1:0]   reg_we,
  output logic              ra_we,
  output logic              rr_we,
  output logic [2:0]        mux_sel,
  output logic              imm_sel,
  output logic              r_sel,
  output logic [IMM_W-1:0]  imm_out,
  output logic [2:0]        alu_op,
  output logic              bus_we,
  output logic              busy,
  output logic              done
);

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   ir;
  logic            accept;

  logic [NREG-1:0] dec_reg_we;
  logic            dec_ra_we;
  logic            dec_rr_we;
  logic            dec_bus_we;
  logic            dec_done;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (instr_valid) begin
          accept  = 1'b1;
          state_n = (opcode_t'(instr_in[OP_MSB:OP_LSB]) == OP_NOP) ? ST_WRITE : ST_LOAD_A;
        end
      end
      ST_LOAD_A: state_n = ST_LOAD_R;
      ST_LOAD_R: state_n = ST_WRITE;
      ST_WRITE:  state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_IDLE;
      ir    <= '0;
    end else begin
      state <= state_n;
      if (accept)
        ir <= instr_in;
    end
  end

  instr_decoder #(
    .IW   (IW),
    .NREG (NREG)
  ) u_decoder (
    .state       (state),
    .ir          (ir),
    .instr_ready (instr_ready),
    .reg_we      (dec_reg_we),
    .ra_we       (dec_ra_we),
    .rr_we       (dec_rr_we),
    .mux_sel     (mux_sel),
    .imm_sel     (imm_sel),
    .r_sel       (r_sel),
    .imm_out     (imm_out),
    .alu_op      (alu_op),
    .bus_we      (dec_bus_we),
    .busy        (busy),
    .done        (dec_done)
  );

  // A reset arriving mid-instruction must never commit a write, even in the
  // cycle it is asserted, so the enables are gated combinationally.
  assign reg_we = clear ? '0 : dec_reg_we;
  assign ra_we  = clear ? 1'b0 : dec_ra_we;
  assign rr_we  = clear ? 1'b0 : dec_rr_we;
  assign bus_we = clear ? 1'b0 : dec_bus_we;
  assign done   = clear ? 1'b0 : dec_done;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected per-cycle outputs are queued
// when an instruction is driven and compared at each falling clock edge.
module tb_control_sequencer;

  typedef struct packed {
    logic       ready;
    logic [7:0] reg_we;
    logic       ra_we;
    logic       rr_we;
    logic [2:0] mux_sel;
    logic       imm_sel;
    logic       r_sel;
    logic [9:0] imm_out;
    logic [2:0] alu_op;
    logic       bus_we;
    logic       busy;
    logic       done;
  } outs_t;

  typedef struct {
    outs_t v;
    string tag;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  reg_we;
  logic        ra_we;
  logic        rr_we;
  logic [2:0]  mux_sel;
  logic        imm_sel;
  logic        r_sel;
  logic [9:0]  imm_out;
  logic [2:0]  alu_op;
  logic        bus_we;
  logic        busy;
  logic        done;

  outs_t obs;
  exp_t  sb[$];
  int    checks = 0;
  int    passed = 0;

  always #5 clock = ~clock;

  control_sequencer #(.IW(16), .NREG(8)) dut (
    .clock       (clock),
    .clear       (clear),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .reg_we      (reg_we),
    .ra_we       (ra_we),
    .rr_we       (rr_we),
    .mux_sel     (mux_sel),
    .imm_sel     (imm_sel),
    .r_sel       (r_sel),
    .imm_out     (imm_out),
    .alu_op      (alu_op),
    .bus_we      (bus_we),
    .busy        (busy),
    .done        (done)
  );

  assign obs = {instr_ready, reg_we, ra_we, rr_we, mux_sel, imm_sel, r_sel,
                imm_out, alu_op, bus_we, busy, done};

  function automatic outs_t blank(input logic [9:0] imm);
    outs_t e;
    e = '0;
    e.imm_out = imm;
    return e;
  endfunction

  function automatic outs_t idle_exp(input logic [9:0] imm);
    outs_t e;
    e = blank(imm);
    e.ready = 1'b1;
    return e;
  endfunction

  task automatic push(input outs_t v, input string tag);
    exp_t x;
    x.v = v;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic check_front();
    exp_t x;
    checks++;
    assert (sb.size() != 0) else begin
      $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
      return;
    end
    x = sb.pop_front();
    assert (obs === x.v) passed++;
    else $error("FAIL %s: observed %h expected %h", x.tag, obs, x.v);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    check_front();
  endtask

  // LDI R3,#0x155 (0xAD55)
  task automatic push_ldi();
    outs_t e;
    e = blank(10'h155); e.busy = 1; e.ra_we = 1; e.mux_sel = 3'd3;
    push(e, "ldi_load_a");
    e = blank(10'h155); e.busy = 1; e.rr_we = 1; e.imm_sel = 1; e.alu_op = 3'b101;
    push(e, "ldi_load_r");
    e = blank(10'h155); e.busy = 1; e.r_sel = 1; e.reg_we = 8'h08; e.done = 1;
    push(e, "ldi_write");
    push(idle_exp(10'h155), "ldi_idle");
  endtask

  // ADD R1,R2 (0x0500)
  task automatic push_add();
    outs_t e;
    e = blank(10'h100); e.busy = 1; e.ra_we = 1; e.mux_sel = 3'd1;
    push(e, "add_load_a");
    e = blank(10'h100); e.busy = 1; e.rr_we = 1; e.mux_sel = 3'd2; e.alu_op = 3'b000;
    push(e, "add_load_r");
    e = blank(10'h100); e.busy = 1; e.r_sel = 1; e.reg_we = 8'h02; e.done = 1;
    push(e, "add_write");
    push(idle_exp(10'h100), "add_idle");
  endtask

  // OUT R5 (0x9400)
  task automatic push_out();
    outs_t e;
    e = blank(10'h000); e.busy = 1; e.ra_we = 1; e.mux_sel = 3'd5;
    push(e, "out_load_a");
    e = blank(10'h000); e.busy = 1; e.rr_we = 1; e.mux_sel = 3'd5; e.alu_op = 3'b100;
    push(e, "out_load_r");
    e = blank(10'h000); e.busy = 1; e.mux_sel = 3'd5; e.bus_we = 1; e.done = 1;
    push(e, "out_write");
    push(idle_exp(10'h000), "out_idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    outs_t e;
    clear       = 1'b1;
    instr_valid = 1'b0;
    instr_in    = 16'h0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    push(idle_exp(10'h000), "reset_idle");
    check_front();
    clear = 1'b0;

    instr_in = 16'hAD55; instr_valid = 1'b1;
    push_ldi();
    tick();
    instr_valid = 1'b0;
    repeat (3) tick();

    instr_in = 16'h0500; instr_valid = 1'b1;
    push_add();
    tick();
    instr_valid = 1'b0;
    repeat (3) tick();

    instr_in = 16'h9400; instr_valid = 1'b1;
    push_out();
    tick();
    instr_valid = 1'b0;
    repeat (3) tick();

    instr_in = 16'hE000; instr_valid = 1'b1;
    e = blank(10'h000); e.busy = 1; e.done = 1;
    push(e, "nop_write");
    push(idle_exp(10'h000), "nop_idle");
    tick();
    instr_valid = 1'b0;
    tick();

    // Reset arrives while ADD R1,R2 sits in LOAD_R, with a new instruction offered.
    instr_in = 16'h0500; instr_valid = 1'b1;
    e = blank(10'h100); e.busy = 1; e.ra_we = 1; e.mux_sel = 3'd1;
    push(e, "clr_load_a");
    e = blank(10'h100); e.busy = 1; e.rr_we = 1; e.mux_sel = 3'd2;
    push(e, "clr_load_r");
    tick();
    instr_valid = 1'b0;
    tick();
    clear = 1'b1; instr_valid = 1'b1;
    #1;
    e = blank(10'h100); e.busy = 1; e.mux_sel = 3'd2;
    push(e, "clr_masked_enables");
    check_front();
    push(idle_exp(10'h000), "clr_idle_ir_zero");
    tick();
    clear = 1'b0; instr_valid = 1'b0;
    push(idle_exp(10'h000), "clr_nothing_accepted");
    tick();

    // Back-to-back stream with instr_valid held high; junk while busy is ignored.
    instr_in = 16'hAD55; instr_valid = 1'b1;
    push_ldi();
    tick();
    instr_in = 16'hE000;
    tick(); tick();
    instr_in = 16'h0500;
    push_add();
    tick();
    tick();
    instr_in = 16'hFFFF;
    tick(); tick();
    instr_in = 16'h9400;
    push_out();
    tick();
    tick();
    instr_in = 16'hE000;
    tick(); tick();
    instr_valid = 1'b0;
    tick();

    checks++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL scoreboard_drained: observed %0d left expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
